// File: rtl/sketch_pkg.sv
// Shared constants and types for the sketch pad drawing blocks.
package sketch_pkg;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int X_WIDTH     = 10;
    localparam int Y_WIDTH     = 10;
    localparam int COLOR_WIDTH = 8;
    localparam int MAX_RADIUS  = 10;
    localparam int R_WIDTH     = 5;
    localparam int D_WIDTH     = 6;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } stamp_state_t;

endpackage

// File: rtl/offset_scanner.sv
// Raster counter over the square of offsets (-r..r, -r..r), dx fastest.
module offset_scanner
    import sketch_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [R_WIDTH-1:0]        load_r,
    input  logic [R_WIDTH-1:0]        r,
    input  logic                      advance,
    output logic signed [D_WIDTH-1:0] dx,
    output logic signed [D_WIDTH-1:0] dy,
    output logic                      last
);

    logic signed [D_WIDTH-1:0] dx_q, dy_q;
    logic signed [D_WIDTH-1:0] neg_load, r_s;

    assign neg_load = -$signed({1'b0, load_r});
    assign r_s      = $signed({1'b0, r});
    assign last     = (dx_q == r_s) && (dy_q == r_s);
    assign dx       = dx_q;
    assign dy       = dy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
        end else if (load) begin
            dx_q <= neg_load;
            dy_q <= neg_load;
        end else if (advance) begin
            if (dx_q == r_s) begin
                dx_q <= -r_s;
                dy_q <= dy_q + 6'sd1;
            end else begin
                dx_q <= dx_q + 6'sd1;
            end
        end
    end

endmodule

// File: rtl/brush_stamp.sv
// Rasterises a filled circle around the cursor into a valid/ready pixel stream.
module brush_stamp
    import sketch_pkg::*;
#(
    parameter int H_RES       = sketch_pkg::H_RES,
    parameter int V_RES       = sketch_pkg::V_RES,
    parameter int X_WIDTH     = sketch_pkg::X_WIDTH,
    parameter int Y_WIDTH     = sketch_pkg::Y_WIDTH,
    parameter int COLOR_WIDTH = sketch_pkg::COLOR_WIDTH,
    parameter int MAX_RADIUS  = sketch_pkg::MAX_RADIUS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [X_WIDTH-1:0]     center_x,
    input  logic [Y_WIDTH-1:0]     center_y,
    input  logic [R_WIDTH-1:0]     radius,
    input  logic [COLOR_WIDTH-1:0] color,
    output logic                   busy,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [X_WIDTH-1:0]     pix_x,
    output logic [Y_WIDTH-1:0]     pix_y,
    output logic [COLOR_WIDTH-1:0] pix_color,
    output logic                   done
);

    stamp_state_t state_q, state_d;

    logic [X_WIDTH-1:0]     cx_q;
    logic [Y_WIDTH-1:0]     cy_q;
    logic [COLOR_WIDTH-1:0] color_q;
    logic [R_WIDTH-1:0]     r_q, r_clamp;

    logic                   pix_valid_q;
    logic [X_WIDTH-1:0]     pix_x_q;
    logic [Y_WIDTH-1:0]     pix_y_q;
    logic [COLOR_WIDTH-1:0] pix_color_q;

    logic signed [D_WIDTH-1:0] dx, dy;
    logic                      last;
    logic                      accept_start, out_free, advance;

    logic [6:0]             ax, ay, sq_x, sq_y;
    logic [7:0]             dist2, r2;
    logic signed [X_WIDTH:0] sx;
    logic signed [Y_WIDTH:0] sy;
    logic                   x_ok, y_ok, hit;

    assign r_clamp      = (radius > R_WIDTH'(MAX_RADIUS)) ? R_WIDTH'(MAX_RADIUS) : radius;
    assign accept_start = (state_q == StIdle) && start;
    assign out_free     = !pix_valid_q || pix_ready;
    assign advance      = (state_q == StScan) && out_free;

    offset_scanner u_scanner (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_start),
        .load_r  (r_clamp),
        .r       (r_q),
        .advance (advance),
        .dx      (dx),
        .dy      (dy),
        .last    (last)
    );

    // Hit test: inside the circle and on screen after signed offsetting.
    always_comb begin
        ax    = 7'(dx[D_WIDTH-1] ? -dx : dx);
        ay    = 7'(dy[D_WIDTH-1] ? -dy : dy);
        sq_x  = ax * ax;
        sq_y  = ay * ay;
        dist2 = {1'b0, sq_x} + {1'b0, sq_y};
        r2    = {3'b0, r_q} * {3'b0, r_q};
        sx    = $signed({1'b0, cx_q}) + (X_WIDTH+1)'(dx);
        sy    = $signed({1'b0, cy_q}) + (Y_WIDTH+1)'(dy);
        x_ok  = !sx[X_WIDTH] && (sx[X_WIDTH-1:0] < X_WIDTH'(H_RES));
        y_ok  = !sy[Y_WIDTH] && (sy[Y_WIDTH-1:0] < Y_WIDTH'(V_RES));
        hit   = (dist2 <= r2) && x_ok && y_ok;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StScan;
            StScan:  if (advance && last) state_d = StDrain;
            StDrain: if (out_free) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                cx_q    <= center_x;
                cy_q    <= center_y;
                color_q <= color;
                r_q     <= r_clamp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
        end else if (advance) begin
            pix_valid_q <= hit;
            if (hit) begin
                pix_x_q     <= sx[X_WIDTH-1:0];
                pix_y_q     <= sy[Y_WIDTH-1:0];
                pix_color_q <= color_q;
            end
        end else if (pix_valid_q && pix_ready) begin
            pix_valid_q <= 1'b0;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;

endmodule
